alu_arbiter: RTL and testbench

- Shares one WIDTH-bit ALU between two requesters (port 0, port 1).
- Provides a valid/ready request handshake and a valid/ready response handshake per port, with round-robin arbitration.
- Executes one operation at a time and holds each result until the owning port accepts it.
- Sits between the instruction-issue logic and the bitwise/arithmetic ALU units.

---
 rtl/alu_arbiter.sv | 91 +++++++++
 tb/tb_alu_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between two valid/ready requesters.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic last_grant, owner, grant, grant_vld;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, f;
  // On a tie the port that did not win last time is granted.
  assign grant_vld = state == IDLE && (req0_valid || req1_valid);
  assign grant = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = grant_vld && !grant;
  assign req1_ready = grant_vld && grant;
  assign busy = state != IDLE;
  always_comb begin
    f = '0;
    case (op)
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: f = a ^ b;
      3'd3: f = ~(a | b);
      3'd4: f = a + b;
      3'd5: f = a - b;
      3'd6: f = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: f = b;
    endcase
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = grant_vld ? EXEC : IDLE;
      EXEC: state_nxt = RESP;
      RESP: state_nxt = (owner ? rsp1_ready : rsp0_ready) ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      owner <= 1'b0;
      op <= '0;
      a <= '0;
      b <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_vld) begin
        owner <= grant;
        last_grant <= grant;
        op <= grant ? req1_op : req0_op;
        a <= grant ? req1_a : req0_a;
        b <= grant ? req1_b : req0_b;
      end
      if (state == EXEC) begin
        rsp_result <= f;
        rsp_zero <= f == '0;
        rsp0_valid <= !owner;
        rsp1_valid <= owner;
      end
      if (state == RESP && state_nxt == IDLE) begin
        rsp0_valid <= 1'b0;
        rsp1_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized + directed scoreboard bench for alu_arbiter.
module tb_alu_arbiter;
  typedef struct packed {logic [2:0] op; logic [31:0] a; logic [31:0] b;} req_t;
  typedef struct {int port; logic [31:0] res; int due;} exp_t;
  logic clk = 0, rst_n = 0;
  logic v[2], r[2];
  logic [2:0] op[2];
  logic [31:0] a[2], b[2];
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, busy;
  logic [31:0] rsp_result;
  int vectors = 0, errs = 0, cyc = 0;
  int phase = 0, mlast = 1, mown = 0, g;
  bit anyv, seen = 0;
  exp_t sb[$];
  exp_t e;
  req_t dq[2][$];

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_op(op[0]), .req0_a(a[0]), .req0_b(b[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_op(op[1]), .req1_a(a[1]), .req1_b(b[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(r[0]), .rsp1_valid(rsp1_valid), .rsp1_ready(r[1]),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] alu(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return x + y;
      3'd5: return x - y;
      3'd6: return (x[31] != y[31]) ? {31'b0, x[31]} : {31'b0, x < y};
      default: return y;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks idle/exec/resp phases from the handshake rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0;
      mlast = 1;
      sb.delete();
    end else begin
      anyv = v[0] || v[1];
      g = (v[0] && v[1]) ? int'(mlast == 0) : (v[1] ? 1 : 0);
      chk("req_ready", 32'({req1_ready, req0_ready}), (phase == 0 && anyv) ? (1 << g) : 0);
      chk("busy", 32'(busy), 32'(phase != 0));
      chk("rsp_valid", 32'({rsp1_valid, rsp0_valid}), phase == 2 ? (1 << mown) : 0);
      case (phase)
        0: if (anyv) begin
          sb.push_back('{g, alu(op[g], a[g], b[g]), cyc + 2});
          mlast = g;
          mown = g;
          phase = 1;
        end
        1: phase = 2;
        default: if (r[mown]) phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (rsp0_valid || rsp1_valid) begin
      if (sb.size() == 0) chk("rsp_unexpected", 32'({rsp1_valid, rsp0_valid}), 0);
      else begin
        e = sb[0];
        if (!seen) chk("latency", cyc, e.due);
        seen = 1;
        chk("rsp_port", 32'({rsp1_valid, rsp0_valid}), 1 << e.port);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_zero", 32'(rsp_zero), 32'(e.res == 0));
        if (r[e.port]) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic run(int n, int pct, bit rr);
    bit hs[2];
    req_t t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs[0] = v[0] && req0_ready;
      hs[1] = v[1] && req1_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++)
        if (!v[p] || hs[p]) begin
          if (dq[p].size() > 0) begin
            t = dq[p].pop_front();
            v[p] = 1; op[p] = t.op; a[p] = t.a; b[p] = t.b;
          end else if (int'($urandom_range(0, 99)) < pct) begin
            v[p] = 1; op[p] = 3'($urandom_range(0, 7)); a[p] = pick(); b[p] = pick();
          end else v[p] = 0;
        end
      if (rr) begin
        r[0] = $urandom_range(0, 3) != 0;
        r[1] = $urandom_range(0, 3) != 0;
      end
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      v[p] = 0; r[p] = 1; op[p] = 0; a[p] = 0; b[p] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset_result", rsp_result, 0);
    chk("reset_zero", 32'(rsp_zero), 0);
    // Sustained tie after reset: grants 0,1,0,1 with wrap, zero and signed-compare corners.
    dq[0].push_back('{3'd5, 32'h0, 32'h1});
    dq[0].push_back('{3'd4, 32'hFFFF_FFFF, 32'h1});
    dq[1].push_back('{3'd6, 32'h8000_0000, 32'h1});
    dq[1].push_back('{3'd6, 32'h1, 32'h8000_0000});
    run(16, 0, 0);
    dq[0].push_back('{3'd1, 32'h0000_F0F0, 32'h0F0F_0000});
    run(6, 0, 0);
    // Port 1 response held off while port 0 waits.
    dq[1].push_back('{3'd2, 32'h1234_5678, 32'hFFFF_0000});
    run(1, 0, 0);
    dq[0].push_back('{3'd3, 32'h0F0F_0F0F, 32'hF0F0_F0F0});
    r[1] = 0;
    run(8, 0, 0);
    r[1] = 1;
    run(8, 0, 0);
    // Reset while the accepted op sits in EXEC.
    dq[0].push_back('{3'd4, 32'd5, 32'd6});
    run(1, 0, 0);
    run(1, 0, 0);
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'({rsp1_valid, rsp0_valid}), 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_zero", 32'(rsp_zero), 0);
    dq[0].push_back('{3'd7, 32'h0, 32'hCAFE_F00D});
    dq[1].push_back('{3'd0, 32'hFF00_FF00, 32'h0FF0_0FF0});
    run(10, 0, 0);
    run(600, 60, 1);
    r[0] = 1;
    r[1] = 1;
    run(12, 0, 0);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
